mant_mul_iter: RTL and testbench
================================

// Module: mant_mul_iter
// PURPOSE
//  Parametrised multi-cycle unsigned mantissa multiplier, successor to the fixed 24x24 combinational one.
//  Consumes BPC multiplier bits per cycle, so area trades against latency.
//  Valid/ready handshakes on input and output; sits between FP unpack and the FP normalise/round stage.
//  Optional normalise stage produces a WIDTH-bit mantissa, exponent-increment flag and sticky bit.
// PARAMETERS
//  WIDTH  24  operand width in bits (24 = single precision incl. hidden bit); >= 2
//  BPC    4   multiplier bits retired per cycle; must divide WIDTH exactly (elaboration error otherwise)
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst_n      in   1        synchronous active-low reset
//  in_valid   in   1        operands present
//  in_ready   out  1        block can accept operands this cycle
//  a_op       in   WIDTH    multiplicand, unsigned
//  b_op       in   WIDTH    multiplier, unsigned
//  out_valid  out  1        r_op (and norm outputs) valid
//  out_ready  in   1        downstream accepts result
//  r_op       out  2*WIDTH  product a_op*b_op, exact, unsigned
//  busy       out  1        high in RUN state
//  norm_mant  out  WIDTH    [MANT_MUL_NORM_EN only] normalised mantissa
//  exp_inc    out  1        [MANT_MUL_NORM_EN only] product MSB set, exponent +1
//  sticky     out  1        [MANT_MUL_NORM_EN only] OR of bits below norm_mant
// BEHAVIOUR
//  - Reset (rst_n==0 at edge): state IDLE, counter 0, acc 0, r_op 0, out_valid 0, busy 0;
//    norm outputs 0. Reset mid-RUN or mid-DONE aborts; the pending result is discarded, no out_valid.
//  - ITER = WIDTH/BPC. FSM IDLE -> RUN -> DONE:
//    IDLE: in_ready=1. On in_valid&in_ready: latch a_op, b_op, acc<=0, k<=0, go RUN.
//    RUN: in_ready=0, busy=1. Each cycle acc <= acc + ((a * b[k*BPC +: BPC]) << (k*BPC)), k<=k+1;
//         after the edge where k==ITER-1 is processed, load r_op<=final acc, go DONE.
//    DONE: out_valid=1, r_op held stable until out_valid&out_ready.
//         On handshake: if in_valid, accept new operands same edge -> RUN; else -> IDLE.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready); combinational from state and out_ready only.
//  - Latency: accept at edge E -> out_valid high in the cycle after edge E+ITER (6 cycles for 24/4).
//    Throughput one result per ITER+1 cycles with out_ready held high.
//  - in_valid while busy is ignored (no accept); operands need not stay stable after acceptance.
//  - Arithmetic: acc 2*WIDTH bits, no overflow possible; partial product WIDTH+BPC bits.
//    Zero operands take the full ITER cycles (fixed latency, no early exit).
//  - Back-pressure: out_ready low in DONE holds all outputs; no state advance.
// CONFIGURATION
//  MANT_MUL_NORM_EN defined: norm_mant/exp_inc/sticky ports exist, registered on the same edge as r_op.
//    exp_inc = P[2W-1]; norm_mant = exp_inc ? P[2W-1:W] : P[2W-2:W-1];
//    sticky = exp_inc ? |P[W-1:0] : |P[W-2:0]. Reset to 0. Latency unchanged.
//  Undefined: those ports and their logic are absent; r_op behaviour identical.
// STRUCTURE
//  Package mant_mul_pkg: state enum {IDLE,RUN,DONE}; function iter_count(WIDTH,BPC);
//    default WIDTH/BPC constants for single/double precision (24/4, 53 requires BPC=1 or 53).
//  Sub-module mant_mul_pp: combinational WIDTH x BPC partial-product generator, instantiated once.
//  Top holds FSM, counter ($clog2(ITER) bits, min 1), operand and accumulator registers.
// TESTING
//  1. WIDTH=24,BPC=4: a=24'hFFFFFF,b=24'hFFFFFF -> r_op=48'hFFFFFE000001 in cycle after edge E+6.
//  2. a=24'h800000,b=24'h800000 -> r_op=48'h400000000000; NORM_EN: exp_inc=0, norm_mant=24'h800000, sticky=0.
//  3. a=24'hC00000,b=24'hC00001 -> exp_inc=1, norm_mant=24'h900000, sticky=1 (NORM_EN).
//  4. out_ready low 5 cycles in DONE -> r_op/out_valid stable, in_ready=0; raise with in_valid -> same-edge accept, next result 7 cycles later.
//  5. rst_n low at RUN cycle 3 -> next cycle state IDLE, out_valid=0, r_op=0, in_ready=1; no stale result later.
//  6. Random 10k pairs at BPC in {1,2,3,4,6,8,12,24} vs a*b reference; a=0 or b=0 -> r_op=0 with latency ITER.

Source files
------------

// File: rtl/mant_mul_pkg.sv
// mant_mul_pkg: shared types and constants for the iterative mantissa multiplier.
// Holds the FSM state enum, iteration count helper and precision presets.
package mant_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Single precision: 24-bit mantissa, 4 bits per cycle.
  localparam int SP_WIDTH = 24;
  localparam int SP_BPC   = 4;

  // Double precision: 53 is prime, so only BPC of 1 or 53 divide it.
  localparam int DP_WIDTH = 53;
  localparam int DP_BPC   = 1;

  function automatic int iter_count(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/mant_mul_pp.sv
// mant_mul_pp: combinational WIDTH x BPC unsigned partial product.
// One instance serves every iteration of the multiplier.
module mant_mul_pp #(
  parameter int WIDTH = 24,
  parameter int BPC   = 4
) (
  input  logic [WIDTH-1:0]     i_a,
  input  logic [BPC-1:0]       i_b,
  output logic [WIDTH+BPC-1:0] o_pp
);

  localparam int PPW = WIDTH + BPC;

  // Product of full multiplicand and one BPC-bit multiplier digit.
  always_comb begin
    o_pp = PPW'(i_a) * PPW'(i_b);
  end

endmodule

// File: rtl/mant_mul_iter.sv
// mant_mul_iter: multi-cycle unsigned mantissa multiplier, BPC bits/cycle.
// Define MANT_MUL_NORM_EN to add norm_mant/exp_inc/sticky outputs.
module mant_mul_iter
  import mant_mul_pkg::*;
#(
  parameter int WIDTH = SP_WIDTH,
  parameter int BPC   = SP_BPC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_op,
  input  logic [WIDTH-1:0]   b_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] r_op,
  output logic               busy
`ifdef MANT_MUL_NORM_EN
  ,
  output logic [WIDTH-1:0]   norm_mant,
  output logic               exp_inc,
  output logic               sticky
`endif
);

  localparam int ITER = iter_count(WIDTH, BPC);
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int PW   = 2 * WIDTH;
  localparam int PPW  = WIDTH + BPC;

  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_cfg
    $error("mant_mul_iter: need WIDTH >= 2 and BPC dividing WIDTH");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    w_pp_sh;
  logic [PW-1:0]    w_acc_nxt;
  logic [PPW-1:0]   w_pp;
  logic [CW-1:0]    r_k;

  // r_b is shifted right each cycle, so its low digit is always digit k.
  mant_mul_pp #(
    .WIDTH(WIDTH),
    .BPC  (BPC)
  ) u_pp (
    .i_a (r_a),
    .i_b (r_b[BPC-1:0]),
    .o_pp(w_pp)
  );

  assign w_pp_sh   = PW'(w_pp) << (r_k * BPC);
  assign w_acc_nxt = r_acc + w_pp_sh;
  assign w_last    = (r_k == CW'(ITER - 1));
  assign w_accept  = in_valid & in_ready;

  // Next state and handshake outputs; in_ready depends on state and out_ready only.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand capture, accumulation and result load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_k   <= '0;
      r_op  <= '0;
    end else if (w_accept) begin
      r_a   <= a_op;
      r_b   <= b_op;
      r_acc <= '0;
      r_k   <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_acc_nxt;
      r_b   <= r_b >> BPC;
      r_k   <= w_last ? '0 : r_k + CW'(1);
      if (w_last) r_op <= w_acc_nxt;
    end
  end

`ifdef MANT_MUL_NORM_EN
  logic             w_ei;
  logic [WIDTH-1:0] w_nm;
  logic             w_st;

  // Normalise the final product: one leading-one position or the next.
  always_comb begin
    w_ei = w_acc_nxt[PW-1];
    w_nm = w_ei ? w_acc_nxt[PW-1:WIDTH] : w_acc_nxt[PW-2:WIDTH-1];
    w_st = w_ei ? |w_acc_nxt[WIDTH-1:0] : |w_acc_nxt[WIDTH-2:0];
  end

  // Norm outputs load on the same edge as r_op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      norm_mant <= '0;
      exp_inc   <= 1'b0;
      sticky    <= 1'b0;
    end else if (!w_accept && r_state == RUN && w_last) begin
      norm_mant <= w_nm;
      exp_inc   <= w_ei;
      sticky    <= w_st;
    end
  end
`endif

endmodule

// File: tb/tb_mant_mul_iter.sv
// tb_mant_mul_iter: vectors, corner sequences and random pairs vs a*b model.
// Build with MANT_MUL_NORM_EN defined to also check normalise outputs.
module tb_mant_mul_iter;

  localparam int W      = 24;
  localparam int M_BPC  = 4;
  localparam int M_ITER = W / M_BPC;
  localparam int N_RND  = 2000;
  localparam int N_GEN  = 200;
  localparam int TMO    = 60;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rst_g_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a_op = '0;
  logic [W-1:0]  b_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] r_op;
  logic          busy;
`ifdef MANT_MUL_NORM_EN
  logic [W-1:0]  norm_mant;
  logic          exp_inc;
  logic          sticky;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mant_mul_iter #(.WIDTH(W), .BPC(M_BPC)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_op     (a_op),
    .b_op     (b_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .r_op     (r_op),
    .busy     (busy)
`ifdef MANT_MUL_NORM_EN
    ,
    .norm_mant(norm_mant),
    .exp_inc  (exp_inc),
    .sticky   (sticky)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    return 64'(a) * 64'(b);
  endfunction

  // Normalised view of a product, by division rather than bit slicing.
  function automatic void ref_norm(input logic [63:0] p, output logic ei,
                                   output logic [W-1:0] nm, output logic st);
    logic [63:0] d;
    ei = (p >= (64'd1 << (2*W-1)));
    d  = ei ? (64'd1 << W) : (64'd1 << (W-1));
    nm = W'(p / d);
    st = (p % d) != 0;
  endfunction

  function automatic int bpc_of(input int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 6;
      4: return 8;
      5: return 12;
      default: return 24;
    endcase
  endfunction

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [47:0]  p;
    logic         ei;
    logic [W-1:0] nm;
    logic         st;
  } vec_t;

  // One transaction on the main DUT; hold = cycles out_ready stays low in DONE.
  task automatic txn(input string nm, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [47:0] ep,
                     input logic eei, input logic [W-1:0] enm,
                     input logic est, input int hold);
    int n;
    chk({nm, " in_ready idle"}, 64'(in_ready), 64'd1);
    a_op = a;
    b_op = b;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_op = W'($urandom);
    b_op = W'($urandom);
    chk({nm, " busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(M_ITER));
    chk({nm, " r_op"}, 64'(r_op), 64'(ep));
`ifdef MANT_MUL_NORM_EN
    chk({nm, " exp_inc"}, 64'(exp_inc), 64'(eei));
    chk({nm, " norm_mant"}, 64'(norm_mant), 64'(enm));
    chk({nm, " sticky"}, 64'(sticky), 64'(est));
`endif
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " out_valid drop"}, 64'(out_valid), 64'd0);
  endtask

  // Extra instances sweep the other BPC values with random pairs.
  for (genvar g = 0; g < 7; g++) begin : g_bpc
    localparam int B  = bpc_of(g);
    localparam int IT = W / B;
    logic           iv;
    logic           ir;
    logic           ov;
    logic           bz;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] r;
    logic           done;
`ifdef MANT_MUL_NORM_EN
    logic [W-1:0]   nm;
    logic           ei;
    logic           st;
`endif

    mant_mul_iter #(.WIDTH(W), .BPC(B)) u (
      .clk      (clk),
      .rst_n    (rst_g_n),
      .in_valid (iv),
      .in_ready (ir),
      .a_op     (a),
      .b_op     (b),
      .out_valid(ov),
      .out_ready(1'b1),
      .r_op     (r),
      .busy     (bz)
`ifdef MANT_MUL_NORM_EN
      ,
      .norm_mant(nm),
      .exp_inc  (ei),
      .sticky   (st)
`endif
    );

    initial begin
      logic [63:0]  p;
      logic         x_ei;
      logic [W-1:0] x_nm;
      logic         x_st;
      int           n;
      int           sel;
      iv = 1'b0;
      a = '0;
      b = '0;
      done = 1'b0;
      wait (rst_g_n === 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < N_GEN; i++) begin
        a = W'($urandom);
        b = W'($urandom);
        sel = $urandom_range(0, 7);
        if (sel == 0) a = '0;
        if (sel == 1) b = '0;
        p = ref_mul(a, b);
        ref_norm(p, x_ei, x_nm, x_st);
        chk($sformatf("bpc%0d in_ready", B), 64'(ir), 64'd1);
        iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        n = 0;
        while (!ov && n < TMO) begin
          @(posedge clk); #1;
          n++;
        end
        chk($sformatf("bpc%0d latency", B), 64'(n), 64'(IT));
        chk($sformatf("bpc%0d r_op", B), 64'(r), p);
`ifdef MANT_MUL_NORM_EN
        chk($sformatf("bpc%0d exp_inc", B), 64'(ei), 64'(x_ei));
        chk($sformatf("bpc%0d norm_mant", B), 64'(nm), 64'(x_nm));
        chk($sformatf("bpc%0d sticky", B), 64'(st), 64'(x_st));
`endif
        @(posedge clk); #1;
      end
      done = 1'b1;
    end
  end

  initial begin
    vec_t         vecs[8];
    logic [63:0]  p;
    logic         x_ei;
    logic [W-1:0] x_nm;
    logic         x_st;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n;
    int           bad;
    int           sel;
    logic         all_done;

    vecs[0] = '{"max*max", 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001,
                1'b1, 24'hFFFFFE, 1'b1};
    vecs[1] = '{"half*half", 24'h800000, 24'h800000, 48'h400000000000,
                1'b0, 24'h800000, 1'b0};
    vecs[2] = '{"c0*c0_1", 24'hC00000, 24'hC00001, 48'h900000C00000,
                1'b1, 24'h900000, 1'b1};
    vecs[3] = '{"zero*max", 24'h000000, 24'hFFFFFF, 48'h0,
                1'b0, 24'h000000, 1'b0};
    vecs[4] = '{"max*zero", 24'hFFFFFF, 24'h000000, 48'h0,
                1'b0, 24'h000000, 1'b0};
    vecs[5] = '{"one*one", 24'h000001, 24'h000001, 48'h1,
                1'b0, 24'h000000, 1'b1};
    vecs[6] = '{"max*one", 24'hFFFFFF, 24'h000001, 48'h000000FFFFFF,
                1'b0, 24'h000001, 1'b1};
    vecs[7] = '{"half*two", 24'h800000, 24'h000002, 48'h000001000000,
                1'b0, 24'h000002, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset r_op", 64'(r_op), 64'd0);
`ifdef MANT_MUL_NORM_EN
    chk("reset norm", {sticky, exp_inc, norm_mant}, 64'd0);
`endif
    rst_n = 1'b1;
    rst_g_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      txn(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].p,
          vecs[i].ei, vecs[i].nm, vecs[i].st, 0);

    // Back-pressure in DONE, then same-edge accept on release.
    out_ready = 1'b0;
    a_op = 24'hFFFFFF;
    b_op = 24'hFFFFFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp latency", 64'(n), 64'(M_ITER));
    chk("bp r_op", 64'(r_op), 64'h0000FFFFFE000001);
    in_valid = 1'b1;
    a_op = 24'h000003;
    b_op = 24'h000005;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || r_op !== 48'hFFFFFE000001 ||
          in_ready !== 1'b0 || busy !== 1'b0)
        bad++;
    end
    chk("bp hold stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_op = '0;
    b_op = '0;
    chk("bp reaccept busy", 64'(busy), 64'd1);
    chk("bp reaccept out_valid", 64'(out_valid), 64'd0);
    n = 0;
    while (!out_valid && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp2 latency", 64'(n), 64'(M_ITER));
    chk("bp2 r_op", 64'(r_op), 64'd15);
    @(posedge clk); #1;

    // Reset during RUN discards the pending product.
    a_op = 24'hABCDEF;
    b_op = 24'h123456;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst r_op", 64'(r_op), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    bad = 0;
    repeat (M_ITER + 4) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rst no stale result", 64'(bad), 64'd0);

    // Random pairs with zero/max injection and random back-pressure.
    for (int i = 0; i < N_RND; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      sel = $urandom_range(0, 15);
      if (sel == 0) ra = '0;
      if (sel == 1) rb = '0;
      if (sel == 2) begin
        ra = '1;
        rb = '1;
      end
      p = ref_mul(ra, rb);
      ref_norm(p, x_ei, x_nm, x_st);
      txn("rnd", ra, rb, p[47:0], x_ei, x_nm, x_st, $urandom_range(0, 2));
    end

    n = 0;
    all_done = 1'b0;
    while (!all_done && n < 20000) begin
      @(posedge clk); #1;
      n++;
      all_done = g_bpc[0].done & g_bpc[1].done & g_bpc[2].done &
                 g_bpc[3].done & g_bpc[4].done & g_bpc[5].done &
                 g_bpc[6].done;
    end
    chk("bpc sweep finished", 64'(all_done), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
